// File: rtl/surf_cout_capture_ctrl.sv
// Capture/captured handshake sequencer for the SURF COUT parallelizer, with a FWFT word FIFO
// and a saturating training bit-error counter. Optional head timestamps: SURF_COUT_CAPTURE_TIMESTAMP_EN.
`timescale 1ns/1ps
module surf_cout_capture_ctrl #(
  parameter int DEPTH         = 8,
  parameter int CAPTURE_DELAY = 12
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic        sync_i,
  input  logic        enable_i,
  input  logic        req_i,
  input  logic        continuous_i,
  input  logic        clr_i,
  input  logic [31:0] cout_parallel_i,
  input  logic        biterr_i,
  output logic        capture_o,
  output logic        captured_o,
  output logic        busy_o,
  output logic [31:0] dout_o,
  output logic [15:0] ts_o,
  output logic        dvalid_o,
  input  logic        dready_i,
  output logic        overflow_o,
  output logic [15:0] biterr_cnt_o
);

  localparam int DATA_W = 32;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int DW     = $clog2(CAPTURE_DELAY + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_SYNC, DELAY, HOLD, STORE, RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        dly_cnt_q;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic [DATA_W-1:0]    mem [DEPTH];
  logic                 full, pop, store, wr_en, ovf_set;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (enable_i && (req_i || continuous_i)) state_d = WAIT_SYNC;
      WAIT_SYNC: if (!enable_i) state_d = IDLE;
                 else if (sync_i) state_d = DELAY;
      DELAY:     if (!enable_i) state_d = IDLE;
                 else if (dly_cnt_q == '0) state_d = HOLD;
      HOLD:      state_d = STORE;
      STORE:     state_d = RELEASE;
      RELEASE:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Sequencer registers; pulses are registered so they line up with HOLD and RELEASE.
  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      dly_cnt_q  <= '0;
      capture_o  <= 1'b0;
      captured_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      capture_o  <= (state_d == HOLD);
      captured_o <= (state_d == RELEASE);
      if (state_q == WAIT_SYNC && sync_i)
        dly_cnt_q <= DW'(CAPTURE_DELAY);
      else if (state_q == DELAY && dly_cnt_q != '0)
        dly_cnt_q <= dly_cnt_q - DW'(1);
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign store    = (state_q == STORE);
  assign full     = (count_q == CW'(DEPTH));
  assign dvalid_o = (count_q != '0);
  assign pop      = dvalid_o && dready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts that word.
  assign wr_en    = store && (!full || pop);
  assign ovf_set  = store && full && !pop;

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_o   <= 1'b0;
      biterr_cnt_o <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_set)    overflow_o <= 1'b1;
      else if (clr_i) overflow_o <= 1'b0;
      if (clr_i)
        biterr_cnt_o <= '0;
      else if (biterr_i && !enable_i)
        biterr_cnt_o <= sat_inc16(biterr_cnt_o);
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (wr_en) mem[wr_ptr_q] <= cout_parallel_i;
  end

  assign dout_o = dvalid_o ? mem[rd_ptr_q] : '0;

`ifdef SURF_COUT_CAPTURE_TIMESTAMP_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] ts_mem [DEPTH];

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i)       frame_cnt_q <= '0;
    else if (sync_i) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  always_ff @(posedge sysclk_i) begin
    if (wr_en) ts_mem[wr_ptr_q] <= frame_cnt_q;
  end

  assign ts_o = dvalid_o ? ts_mem[rd_ptr_q] : 16'h0000;
`else
  assign ts_o = 16'h0000;
`endif

endmodule

// File: tb/tb_surf_cout_capture_ctrl.sv
// Randomized bench for surf_cout_capture_ctrl against a cycle-indexed transaction model.
`timescale 1ns/1ps
module tb_surf_cout_capture_ctrl;

  localparam int D   = 12;
  localparam int DEP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync, en, req, cont, clr, biterr, dready;
  logic [31:0] cout;
  logic        capture, captured, busy, dvalid, overflow;
  logic [31:0] dout;
  logic [15:0] ts, becnt;

  surf_cout_capture_ctrl #(.DEPTH(DEP), .CAPTURE_DELAY(D)) dut (
    .sysclk_i(clk), .rst_i(rst), .sync_i(sync), .enable_i(en), .req_i(req),
    .continuous_i(cont), .clr_i(clr), .cout_parallel_i(cout), .biterr_i(biterr),
    .capture_o(capture), .captured_o(captured), .busy_o(busy), .dout_o(dout),
    .ts_o(ts), .dvalid_o(dvalid), .dready_i(dready), .overflow_o(overflow),
    .biterr_cnt_o(becnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: k is the cycle whose inputs are applied next; fire is the cycle sync was taken.
  int          k = 0;
  bit          armed;
  int          fire;
  logic [31:0] q[$];
  logic [15:0] tq[$];
  bit          m_ovf;
  logic [15:0] m_bec, m_fc;

  logic s_en, s_req, s_cont, s_clr, s_biterr, s_dready;
  logic [31:0] s_cout;

  task automatic model_reset();
    armed = 0; fire = -1; q.delete(); tq.delete(); m_ovf = 0; m_bec = 0; m_fc = 0;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_capture"}, 32'(capture), 0);
    chk({tag, "_captured"}, 32'(captured), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_dvalid"}, 32'(dvalid), 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_ts"}, 32'(ts), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_bec"}, 32'(becnt), 0);
  endtask

  task automatic cycle();
    int  p;
    bit  pop, st, wr, oset, sy;
    @(negedge clk);
    p = k - fire;
    chk("busy", 32'(busy), 32'(armed || fire >= 0));
    chk("capture", 32'(capture), 32'(fire >= 0 && p == D + 2));
    chk("captured", 32'(captured), 32'(fire >= 0 && p == D + 4));
    chk("dvalid", 32'(dvalid), 32'(q.size() != 0));
    chk("dout", dout, (q.size() != 0) ? q[0] : 32'h0);
`ifdef SURF_COUT_CAPTURE_TIMESTAMP_EN
    chk("ts", 32'(ts), (tq.size() != 0) ? 32'(tq[0]) : 32'h0);
`else
    chk("ts", 32'(ts), 32'h0);
`endif
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("biterr_cnt", 32'(becnt), 32'(m_bec));

    sy = (k % 16 == 0);
    sync = sy; en = s_en; req = s_req; cont = s_cont; clr = s_clr;
    biterr = s_biterr; dready = s_dready; cout = s_cout;

    pop  = (q.size() != 0) && s_dready;
    st   = (fire >= 0) && (p == D + 3);
    wr   = st && (q.size() < DEP || pop);
    oset = st && (q.size() == DEP) && !pop;
    if (pop) begin void'(q.pop_front()); void'(tq.pop_front()); end
    if (wr) begin q.push_back(s_cout); tq.push_back(m_fc); end
    if (oset) m_ovf = 1;
    else if (s_clr) m_ovf = 0;
    if (s_clr) m_bec = 0;
    else if (s_biterr && !s_en && m_bec != 16'hFFFF) m_bec = m_bec + 16'd1;
    if (fire >= 0) begin
      if ((p <= D + 1 && !s_en) || p == D + 4) fire = -1;
    end else if (armed) begin
      if (!s_en) armed = 0;
      else if (sy) begin armed = 0; fire = k; end
    end else if (s_en && (s_req || s_cont)) armed = 1;
    if (sy) m_fc = m_fc + 16'd1;
    k++;
  endtask

  task automatic idle_inputs();
    s_en = 1; s_req = 0; s_cont = 0; s_clr = 0; s_biterr = 0; s_dready = 0; s_cout = $urandom();
  endtask

  task automatic run_to_phase(input int ph, output bit found);
    found = 0;
    s_en = 1; s_req = 1;
    for (int i = 0; i < 100 && !found; i++) begin
      s_cout = $urandom();
      cycle();
      if (fire >= 0 && k - fire == ph) found = 1;
    end
    s_req = 0;
  endtask

  initial begin
    bit found;
    rst = 1; sync = 0; en = 0; req = 0; cont = 0; clr = 0; biterr = 0; dready = 0; cout = 0;
    model_reset();
    idle_inputs();
    #1 reset_check("por");
    repeat (2) @(negedge clk);
    rst = 0;

    // Single request, FIFO held, then drained.
    idle_inputs();
    s_req = 1; cycle(); s_req = 0;
    for (int i = 0; i < 40; i++) begin s_cout = $urandom(); cycle(); end
    s_dready = 1; for (int i = 0; i < 4; i++) cycle();

    // Continuous capture into a stalled FIFO until overflow, then clear and drain.
    idle_inputs(); s_cont = 1;
    for (int i = 0; i < 16 * 20; i++) begin s_cout = $urandom(); cycle(); end
    s_cont = 0;
    for (int i = 0; i < 40; i++) cycle();
    s_clr = 1; cycle(); s_clr = 0;
    s_dready = 1; for (int i = 0; i < 12; i++) cycle();

    // Enable dropped in DELAY (aborts) and in HOLD (completes).
    idle_inputs();
    run_to_phase(5, found);
    chk("reach_delay", 32'(found), 1);
    s_en = 0; for (int i = 0; i < 24; i++) cycle();
    s_en = 1;
    run_to_phase(D + 2, found);
    chk("reach_hold", 32'(found), 1);
    s_en = 0; for (int i = 0; i < 24; i++) cycle();

    // Random traffic.
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      s_en     = ($urandom_range(0, 9) != 0);
      s_req    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) s_cont = ~s_cont;
      s_clr    = ($urandom_range(0, 49) == 0);
      s_biterr = 1'($urandom_range(0, 1));
      s_dready = ($urandom_range(0, 3) == 0);
      s_cout   = $urandom();
      cycle();
    end

    // Training-mode bit-error saturation, clear against a live error.
    idle_inputs(); s_en = 0; s_biterr = 1; s_dready = 1;
    for (int i = 0; i < 70000; i++) cycle();
    chk("bec_saturated", 32'(becnt), 32'hFFFF);
    s_clr = 1; cycle(); s_clr = 0;
    cycle();
    chk("bec_after_clr", 32'(becnt), 0);
    cycle();
    chk("bec_after_clr_plus1", 32'(becnt), 1);

    // Asynchronous reset landing in STORE.
    idle_inputs(); s_dready = 1;
    run_to_phase(D + 3, found);
    chk("reach_store", 32'(found), 1);
    @(posedge clk); #2;
    rst = 1;
    #1 reset_check("rst_store");
    @(negedge clk);
    sync = 0; en = 0; req = 0; cont = 0; clr = 0; biterr = 0; dready = 0;
    @(posedge clk); #1;
    chk("rst_no_captured", 32'(captured), 0);
    @(negedge clk);
    rst = 0;
    model_reset(); idle_inputs();
    for (int i = 0; i < 40; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
